// File: rtl/viterbi_dec_322_if.sv
// Symbol-in / pair-out bus of the rate-2/3 Viterbi decoder.
interface viterbi_dec_322_if;
  logic [2:0] Vx;
  logic       vx_valid;
  logic [1:0] Ux_hat;
  logic       ux_valid;
  logic       ux_last;
  logic       tb_en;

  modport master (output Vx, vx_valid, input Ux_hat, ux_valid, ux_last, tb_en);
  modport slave  (input Vx, vx_valid, output Ux_hat, ux_valid, ux_last, tb_en);
endinterface

// File: rtl/viterbi_dec_322.sv
// Hard-decision Viterbi decoder for the (3,2,2) code: per-symbol ACS with
// metric normalisation, full-frame survivor memory, traceback, then output.
module viterbi_dec_322 #(
  parameter int unsigned FRAME_LEN = 32
) (
  input logic              clock,
  input logic              reset_n,
  viterbi_dec_322_if.slave bus
);
  localparam int unsigned CW = $clog2(FRAME_LEN + 1);
  localparam int unsigned AW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] K_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] K_END  = CW'(FRAME_LEN);

  typedef enum logic [1:0] {S_IDLE, S_ACS, S_TRACE, S_OUTPUT} state_t;

  state_t        fsm_q;
  logic [CW-1:0] k_q;
  logic [4:0]    pm_q [8];
  logic [15:0]   surv_q [FRAME_LEN];
  logic [1:0]    obuf_q [FRAME_LEN];
  logic [2:0]    ts_q;
  logic [1:0]    ux_hat_q;
  logic          ux_valid_q;
  logic          ux_last_q;
  logic          tb_en_q;

  logic [5:0]    acc_d [8];
  logic [4:0]    pm_d [8];
  logic [5:0]    min_d;
  logic [2:0]    best_d;
  logic [15:0]   dec_d;
  logic [AW-1:0] k_idx;
  logic [1:0]    trace_dec;
  logic          accept;

  // Predecessor {a,b,c} of next state n for predecessor index i = {a,c}.
  function automatic logic [2:0] pred_state(input logic [2:0] n, input logic [1:0] i);
    return {i[1], n[0], i[0]};
  endfunction

  // Hamming distance between received symbol and branch output p -> n.
  function automatic logic [1:0] branch_metric(input logic [2:0] p, input logic [2:0] n,
                                               input logic [2:0] v);
    logic [2:0] e;
    e[0] = n[2] ^ p[2] ^ p[1];
    e[1] = n[1] ^ p[2] ^ p[0];
    e[2] = n[2] ^ n[1] ^ p[0];
    e    = e ^ v;
    return {1'b0, e[0]} + {1'b0, e[1]} + {1'b0, e[2]};
  endfunction

  assign accept    = bus.vx_valid && !tb_en_q;
  assign k_idx     = k_q[AW-1:0];
  assign trace_dec = surv_q[k_idx][{ts_q, 1'b0} +: 2];

  // Add-compare-select over 4 predecessors, then normalise to the minimum.
  always_comb begin
    dec_d  = '0;
    min_d  = '1;
    best_d = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      acc_d[n] = '1;
      for (int unsigned i = 0; i < 4; i++) begin
        logic [5:0] cand;
        cand = {1'b0, pm_q[pred_state(3'(n), 2'(i))]}
             + 6'(branch_metric(pred_state(3'(n), 2'(i)), 3'(n), bus.Vx));
        if (cand < acc_d[n]) begin
          acc_d[n]          = cand;
          dec_d[2*n +: 2]   = 2'(i);
        end
      end
    end
    for (int unsigned n = 0; n < 8; n++) begin
      if (acc_d[n] < min_d) begin
        min_d  = acc_d[n];
        best_d = 3'(n);
      end
    end
    for (int unsigned n = 0; n < 8; n++) begin
      pm_d[n] = 5'(acc_d[n] - min_d);
    end
  end

  // Survivor and output-buffer storage; no reset needed, always written before read.
  always_ff @(posedge clock) begin
    if (accept) begin
      surv_q[k_idx] <= dec_d;
    end
    if (fsm_q == S_TRACE) begin
      obuf_q[k_idx] <= {ts_q[1], ts_q[2]};
    end
  end

  // Frame control FSM with registered outputs.
  // The last traceback step forwards buffer[0] straight to the output so the
  // first pair appears without an extra buffer-read cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q      <= S_IDLE;
      k_q        <= '0;
      ts_q       <= '0;
      ux_hat_q   <= '0;
      ux_valid_q <= 1'b0;
      ux_last_q  <= 1'b0;
      tb_en_q    <= 1'b0;
      for (int unsigned n = 0; n < 8; n++) pm_q[n] <= (n == 0) ? 5'd0 : 5'd16;
    end else begin
      unique case (fsm_q)
        S_IDLE, S_ACS: begin
          if (accept) begin
            for (int unsigned n = 0; n < 8; n++) pm_q[n] <= pm_d[n];
            if (k_q == K_LAST) begin
              fsm_q   <= S_TRACE;
              ts_q    <= best_d;
              tb_en_q <= 1'b1;
            end else begin
              fsm_q <= S_ACS;
              k_q   <= k_q + 1'b1;
            end
          end
        end
        S_TRACE: begin
          ts_q <= {trace_dec[1], ts_q[0], trace_dec[0]};
          if (k_q == '0) begin
            ux_hat_q   <= {ts_q[1], ts_q[2]};
            ux_valid_q <= 1'b1;
            k_q        <= CW'(1);
            fsm_q      <= S_OUTPUT;
          end else begin
            k_q <= k_q - 1'b1;
          end
        end
        S_OUTPUT: begin
          if (k_q == K_END) begin
            ux_hat_q   <= '0;
            ux_valid_q <= 1'b0;
            ux_last_q  <= 1'b0;
            tb_en_q    <= 1'b0;
            k_q        <= '0;
            fsm_q      <= S_IDLE;
            for (int unsigned n = 0; n < 8; n++) pm_q[n] <= (n == 0) ? 5'd0 : 5'd16;
          end else begin
            ux_hat_q  <= obuf_q[k_idx];
            ux_last_q <= (k_q == K_LAST);
            k_q       <= k_q + 1'b1;
          end
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  assign bus.Ux_hat   = ux_hat_q;
  assign bus.ux_valid = ux_valid_q;
  assign bus.ux_last  = ux_last_q;
  assign bus.tb_en    = tb_en_q;
endmodule

// File: tb/tb_viterbi_dec_322.sv
// Scoreboard bench for viterbi_dec_322: frames are encoded and decoded by a
// behavioural model; a monitor checks every decoder output against the queue.
module tb_viterbi_dec_322;
  localparam int unsigned N = 32;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  viterbi_dec_322_if bus ();

  viterbi_dec_322 #(.FRAME_LEN(N)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [1:0] pair;
    logic       last;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done_req = 1'b0;
  bit   done_ack = 1'b0;

  logic [1:0] tx   [N];
  logic [2:0] errm [N];
  logic [2:0] rx   [N];
  logic [1:0] dref [N];

  // ---------------- behavioural code model ----------------
  function automatic logic [2:0] code_out(int unsigned st, int unsigned u1, int unsigned u0);
    int unsigned a, b, c;
    a = (st >> 2) & 1;
    b = (st >> 1) & 1;
    c = st & 1;
    return 3'(((u0 + u1 + c) % 2) * 4 + ((u1 + a + c) % 2) * 2 + ((u0 + a + b) % 2));
  endfunction

  function automatic int unsigned next_st(int unsigned st, int unsigned u1, int unsigned u0);
    return u0 * 4 + u1 * 2 + ((st >> 1) & 1);
  endfunction

  // Full-path Viterbi: each state carries its whole decoded history.
  task automatic ref_decode();
    int unsigned pm [8];
    int unsigned npm [8];
    logic [1:0]  path [8][N];
    logic [1:0]  npath [8][N];
    int unsigned start;
    for (int s = 0; s < 8; s++) begin
      pm[s] = (s == 0) ? 0 : 16;
      for (int j = 0; j < N; j++) path[s][j] = 2'b00;
    end
    for (int k = 0; k < N; k++) begin
      for (int ns = 0; ns < 8; ns++) begin
        int unsigned best, bp, bu;
        best = 1000; bp = 0; bu = 0;
        for (int ps = 0; ps < 8; ps++) begin
          for (int u = 0; u < 4; u++) begin
            if (next_st(ps, u >> 1, u & 1) == ns) begin
              int unsigned cand;
              cand = pm[ps] + $countones(code_out(ps, u >> 1, u & 1) ^ rx[k]);
              if (cand < best) begin best = cand; bp = ps; bu = u; end
            end
          end
        end
        npm[ns] = best;
        for (int j = 0; j < N; j++) npath[ns][j] = path[bp][j];
        npath[ns][k] = 2'(bu);
      end
      for (int s = 0; s < 8; s++) begin
        pm[s] = npm[s];
        for (int j = 0; j < N; j++) path[s][j] = npath[s][j];
      end
    end
    start = 0;
    for (int s = 1; s < 8; s++) if (pm[s] < pm[start]) start = s;
    for (int j = 0; j < N; j++) dref[j] = path[start][j];
  endtask

  // ---------------- stimulus ----------------
  task automatic clear_err();
    for (int k = 0; k < N; k++) errm[k] = 3'b000;
  endtask

  task automatic new_pattern();
    for (int k = 0; k < N; k++) tx[k] = 2'($urandom);
  endtask

  task automatic run_frame(input bit gaps, input bit stall, input bit expect_out);
    int unsigned st;
    bit fell;
    st = 0;
    for (int k = 0; k < N; k++) begin
      rx[k] = code_out(st, tx[k][1], tx[k][0]) ^ errm[k];
      st    = next_st(st, tx[k][1], tx[k][0]);
    end
    if (expect_out) begin
      ref_decode();
      for (int k = 0; k < N; k++) sb_q.push_back('{pair: dref[k], last: (k == N - 1)});
    end
    for (int k = 0; k < N; k++) begin
      bus.vx_valid = 1'b1;
      bus.Vx       = rx[k];
      @(posedge clock); #1;
      if (gaps && k != N - 1) begin
        bus.vx_valid = 1'b0;
        bus.Vx       = 3'($urandom);
        @(posedge clock); #1;
      end
    end
    bus.vx_valid = 1'b0;
    if (!expect_out) return;
    fell = 1'b0;
    for (int c = 0; c < 4 * N; c++) begin
      if (stall) begin
        bus.vx_valid = 1'b1;
        bus.Vx       = 3'($urandom);
      end
      @(posedge clock); #1;
      if (!bus.tb_en) begin fell = 1'b1; break; end
    end
    bus.vx_valid = 1'b0;
    if (!fell) begin
      $display("FAIL frame_end_timeout: tb_en still %0d, required 0", bus.tb_en);
      $fatal(1);
    end
  endtask

  initial begin
    bus.Vx       = 3'b000;
    bus.vx_valid = 1'b0;
    void'($urandom(1));
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    // all-zero frame
    for (int k = 0; k < N; k++) tx[k] = 2'b00;
    clear_err();
    run_frame(1'b0, 1'b0, 1'b1);

    // random frame, then single error, then one error per 8 symbols
    new_pattern();
    run_frame(1'b0, 1'b0, 1'b1);
    errm[10] = 3'b010;
    run_frame(1'b0, 1'b0, 1'b1);
    clear_err();
    for (int k = 3; k < N; k += 8) errm[k] = 3'(1 << $urandom_range(0, 2));
    run_frame(1'b0, 1'b0, 1'b1);

    // same frame with vx_valid toggling
    clear_err();
    run_frame(1'b1, 1'b0, 1'b1);

    // garbage during tb_en, then a fresh frame
    run_frame(1'b0, 1'b1, 1'b1);
    new_pattern();
    run_frame(1'b0, 1'b0, 1'b1);

    // reset at traceback step 5, then a clean frame
    new_pattern();
    run_frame(1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clock);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    new_pattern();
    run_frame(1'b0, 1'b0, 1'b1);

    // a few more random frames with random gaps and sparse errors
    for (int f = 0; f < 3; f++) begin
      new_pattern();
      clear_err();
      errm[$urandom_range(2, N - 6)] = 3'(1 << $urandom_range(0, 2));
      run_frame(1'($urandom), 1'($urandom), 1'b1);
    end

    for (int c = 0; c < 4 * N && sb_q.size() != 0; c++) @(posedge clock);
    done_req = 1'b1;
    for (int c = 0; c < 10 && !done_ack; c++) @(posedge clock);
    if (!done_ack) begin
      $display("FAIL drain_timeout: ack %0d, required 1", done_ack);
      $fatal(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- monitor ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  int unsigned acc_cnt = 0;
  int unsigned run_len = 0;
  bit          exp_rise = 1'b0;
  bit          seen_out = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      chk("reset_outputs", int'({bus.Ux_hat, bus.ux_valid, bus.ux_last, bus.tb_en}), 0);
      acc_cnt  = 0;
      run_len  = 0;
      exp_rise = 1'b0;
      seen_out = 1'b0;
    end else begin
      if (exp_rise) begin
        chk("tb_en_rise", int'(bus.tb_en), 1);
        exp_rise = 1'b0;
      end
      if (bus.vx_valid && !bus.tb_en) begin
        acc_cnt++;
        if (acc_cnt == N) begin
          acc_cnt  = 0;
          exp_rise = 1'b1;
        end
      end
      if (bus.tb_en) begin
        run_len++;
      end else if (run_len != 0) begin
        chk("tb_en_length", int'(run_len), 2 * N);
        run_len  = 0;
        seen_out = 1'b0;
      end
      if (bus.ux_valid) begin
        if (!seen_out) begin
          chk("first_out_latency", int'(run_len), N + 1);
          seen_out = 1'b1;
        end
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("Ux_hat", int'(bus.Ux_hat), int'(e.pair));
          chk("ux_last", int'(bus.ux_last), int'(e.last));
        end
      end
      if (done_req && !done_ack) begin
        chk("scoreboard_drained", sb_q.size(), 0);
        done_ack = 1'b1;
      end
    end
  end
endmodule

// File: doc/viterbi_dec_322.md
# viterbi_dec_322

Hard-decision Viterbi decoder for the rate-2/3 (3,2,2) convolutional code in this codebase. It recovers the 2-bit input pairs Ux from the received 3-bit code symbols Vx. The block decodes fixed-length frames and performs a survivor traceback at frame end. During traceback and output it drives `tb_en` high, which is the same signal that stalls the encoder.

## Interface
- FRAME_LEN, 32: symbol pairs per frame; legal range 4..256.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- Vx  in  3  received code symbol, same bit order as the encoder output.
- vx_valid  in  1  Vx is valid this cycle; sampled only while `tb_en`=0.
- Ux_hat  out  2  decoded pair {u1,u0}; same bit order as the encoder's Ux.
- ux_valid  out  1  Ux_hat is valid this cycle.
- ux_last  out  1  marks the final decoded pair of the frame.
- tb_en  out  1  high during TRACE and OUTPUT; symbol input is stalled while high.

## Operation
- Trellis:
  - State is {a,b,c} = {last u0, last u1, u1 before that}, giving 8 states.
  - Input {u1,u0} from state {a,b,c} moves to next state {u0,u1,b}.
  - Branch outputs are Vx[0]=u0^a^b, Vx[1]=u1^a^c, Vx[2]=u0^u1^c.
  - Each next state fixes its own input: u0=a', u1=b'.
  - The 4 predecessors of a state share b=c'. They are indexed by the 2-bit index {a,c}.
- Branch metric: Hamming distance between Vx and the branch output (0..3).
- Path metrics:
  - 8 metrics, 5 bits each, unsigned.
  - At start of frame: state 0 = 0, all other states = 16.
- ACS, once per accepted symbol:
  - For each state, pick the minimum of (predecessor metric + branch metric) over its 4 predecessors.
  - Ties go to the lowest predecessor index.
  - After ACS, subtract the minimum of the 8 new metrics from all of them. The stored minimum is therefore always 0, and metrics cannot overflow.
- Survivor memory:
  - FRAME_LEN x 16 bits, written at step index k.
  - Each entry holds 8 x 2-bit predecessor indices, one per state.
- FSM (IDLE, ACS, TRACE, OUTPUT):
  - IDLE -> ACS on the first accepted symbol; that symbol is processed in that cycle.
  - ACS -> TRACE when symbol FRAME_LEN-1 is accepted.
  - On the TRACE transition, register the start state as the minimum-metric state (lowest index on ties).
  - TRACE:
    - Runs for FRAME_LEN cycles, stepping k = FRAME_LEN-1 down to 0.
    - Each step writes {b',a'} of the current state into output buffer[k].
    - Next state is {dec[1], c', dec[0]}, where dec is survivor[k][state].
  - OUTPUT:
    - Runs for FRAME_LEN cycles, emitting buffer[0..FRAME_LEN-1] in order with ux_valid=1.
    - ux_last=1 on index FRAME_LEN-1.
    - Then metrics are re-initialised and the FSM returns to IDLE.
- Symbol k of a frame corresponds to the encoder input pair clocked k cycles after the frame's first pair. Aligning for the encoder's registered output is the integrator's job.

## Timing
- Reset values:
  - Outputs: Ux_hat=0, ux_valid=0, ux_last=0, tb_en=0.
  - Internal: FSM=IDLE, step counter=0, metrics initialised.
- One symbol is accepted per cycle when vx_valid=1 and tb_en=0. Gaps in vx_valid do not change state.
- tb_en rises on the cycle after the last symbol is accepted and stays high for exactly 2*FRAME_LEN cycles.
- Inputs presented while tb_en=1 are ignored and cause no metric change.
- The first ux_valid appears FRAME_LEN+1 cycles after the last symbol is accepted. Output pairs are contiguous.
- The next frame may start on the cycle tb_en falls.
- Reset asserted mid-frame, TRACE, or OUTPUT: outputs clear immediately, with no partial frame output. The frame is discarded.

## Test plan
- All-zero frame: FRAME_LEN=32, Vx=0 for 32 cycles. Expect tb_en high for 64 cycles and 32 outputs with Ux_hat=0; ux_last on the 32nd.
- Known sequence from the zero state:
  - Pair 01 must produce Vx=3'b101.
  - Pair 10 from the zero state produces Vx=3'b110.
  - Feed an encoder-generated frame of a random pattern (seed 1). Expect the identical pattern out, pair for pair.
- Single error: flip Vx[1] of symbol 10 in the random frame. Expect error-free output. Repeat with one flip per 8 symbols, also error-free.
- Valid gaps: the same frame with vx_valid toggling 1/0. Expect identical output and an unchanged tb_en duration.
- Stall: drive vx_valid=1 with garbage Vx during tb_en. Expect the next frame to decode correctly from zero-state metrics.
- Reset mid-TRACE: assert reset_n=0 at TRACE step 5. Expect outputs 0 at once, no ux_valid, and a clean decode of the next frame.
